sample_ram_arbiter: RTL and testbench
=====================================

SAMPLE_RAM_ARBITER -- requirements
Module: sample_ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, sample RAM address width (8192 samples).
REQ-002 SHALL have parameter DW, default 16, sample word width.
REQ-003 SHALL have parameter RAM_LATENCY, default 2, RAM read latency in cycles; legal range 1..4.
REQ-004 SHALL have parameter MAX_BURST, default 16, reader beats before a forced yield; legal range 2..256.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: adc_req  in  1  write request; adc_addr  in  AW  write address; adc_wdata  in  DW  write data; adc_gnt  out  1  write accepted.
REQ-007 SHALL have ports: fft_req  in  1  read request; fft_addr  in  AW  read address; fft_gnt  out  1  read accepted; fft_rvalid  out  1  read data valid; fft_rdata  out  DW  read data.
REQ-008 SHALL have ports: host_req  in  1  read request; host_addr  in  AW  read address; host_gnt  out  1  read accepted; host_rvalid  out  1  read data valid; host_rdata  out  DW  read data.
REQ-009 SHALL have ports: ram_en  out  1  RAM enable; ram_we  out  1  RAM write enable; ram_addr  out  AW  RAM address; ram_wdata  out  DW  RAM write data; ram_rdata  in  DW  RAM read data.
REQ-010 SHALL have ports: busy  out  1  any read outstanding in the pipeline; stall_cnt  out  16  reader-stall cycle count.

Function
REQ-011 SHALL transfer a beat in any cycle where a requester's req and gnt are both 1; gnt is combinational from req and registered state.
REQ-012 SHALL grant adc_req in the same cycle, unconditionally; no reader gnt is asserted in that cycle.
REQ-013 SHALL track reader ownership with FSM states OWN_NONE, OWN_FFT, OWN_HOST.
REQ-014 In OWN_NONE with no ADC beat, SHALL grant a sole requesting reader and enter its state; if both request, SHALL grant the reader not served most recently (rr bit; reset value favours fft).
REQ-015 In OWN_FFT/OWN_HOST, SHALL grant the owner whenever its req=1 and adc_req=0, counting each granted beat in a burst counter.
REQ-016 SHALL return to OWN_NONE when the owner's req=0 at a cycle boundary, clearing the burst counter.
REQ-017 When the burst counter reaches MAX_BURST and the other reader's req=1, SHALL hand ownership directly to the other reader (counter cleared, rr updated); if the other reader is idle, the owner keeps ownership and the counter saturates.
REQ-018 If owner drop and burst expiry coincide, SHALL apply REQ-016 first; the other reader is granted in the next cycle via REQ-014.
REQ-019 SHALL not advance the burst counter in ADC-preempted cycles.
REQ-020 SHALL register the accepted beat onto ram_en/ram_we/ram_addr/ram_wdata exactly one cycle after acceptance; ram_en=0 in cycles following no beat.
REQ-021 SHALL assert the matching rvalid for exactly one cycle, 1+RAM_LATENCY cycles after read acceptance, with rdata = ram_rdata in that cycle; in-order, one beat per cycle sustained.
REQ-022 SHALL carry a requester tag through a RAM_LATENCY+1 stage shift register; writes carry no tag and produce no rvalid.
REQ-023 SHALL hold busy=1 while any read tag is in flight.
REQ-024 SHALL increment stall_cnt on each cycle where any reader req=1 and that reader's gnt=0, saturating at 0xFFFF.

Reset
REQ-025 On reset, SHALL clear FSM to OWN_NONE, rr to favour fft, burst counter, tag pipeline, and stall_cnt.
REQ-026 During and after reset, all outputs SHALL be 0: gnts, ram_*, rvalids, rdatas, busy.
REQ-027 Reset mid-read SHALL discard in-flight tags; no rvalid SHALL appear for beats accepted before reset.

Structure
REQ-028 Ownership-state encoding and the requester-tag encoding (none/fft/host) SHALL live in the shared project package.
REQ-029 The tag delay line SHALL be one sub-module, rd_tag_pipe, parameterised by depth.

Verification
REQ-030 fft_req held, addr 0..31, host idle -> 32 consecutive grants; fft_rvalid first 3 cycles after first accept; data matches RAM model.
REQ-031 fft and host both held from the same cycle -> fft gets 16 beats, then host 16, alternating; stall_cnt increments every cycle.
REQ-032 adc_req pulses every 4th cycle during an fft burst -> adc_gnt on every pulse; ram_we=1 one cycle later with its addr/data; fft burst counter advances only on non-ADC cycles.
REQ-033 fft drops req at beat 16 while host requests -> OWN_NONE for one cycle, then host granted.
REQ-034 reset asserted 1 cycle after a host read accept -> no host_rvalid afterwards; busy=0; stall_cnt=0.
REQ-035 host requests alone for 300 cycles -> no yield, continuous grants, stall_cnt stays 0.

Source files
------------

// File: rtl/sample_ram_arbiter_pkg.sv
// Shared encodings for the sample RAM arbiter: reader ownership states and
// the requester tags that ride alongside reads through the RAM latency.
package sample_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FFT  = 2'd1,
    OWN_HOST = 2'd2
  } own_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_FFT  = 2'd1,
    TAG_HOST = 2'd2
  } tag_t;

  localparam int STALL_W = 16;

  function automatic own_t other_reader(own_t own);
    return (own == OWN_FFT) ? OWN_HOST : OWN_FFT;
  endfunction

endpackage

// File: rtl/sample_ram_arbiter_rd_tag_pipe.sv
// Requester-tag delay line matching the RAM read latency; busy flags any
// read still travelling towards its return cycle.
module rd_tag_pipe
  import sample_ram_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic busy
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= TAG_NONE;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stages[i] != TAG_NONE) busy = 1'b1;
    end
  end

endmodule

// File: rtl/sample_ram_arbiter.sv
// Single-port sample RAM arbiter: the ADC writer always wins, the FFT and host
// readers share the remaining cycles in bounded bursts.
module sample_ram_arbiter
  import sample_ram_arbiter_pkg::*;
#(
  parameter int AW          = 13,
  parameter int DW          = 16,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               adc_req,
  input  logic [AW-1:0]      adc_addr,
  input  logic [DW-1:0]      adc_wdata,
  output logic               adc_gnt,
  input  logic               fft_req,
  input  logic [AW-1:0]      fft_addr,
  output logic               fft_gnt,
  output logic               fft_rvalid,
  output logic [DW-1:0]      fft_rdata,
  input  logic               host_req,
  input  logic [AW-1:0]      host_addr,
  output logic               host_gnt,
  output logic               host_rvalid,
  output logic [DW-1:0]      host_rdata,
  output logic               ram_en,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_rdata,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

  own_t          state;
  logic          rr_host;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] cnt_next;
  logic          fft_pick;
  logic          host_pick;
  logic          beat;
  logic          owner_req;
  logic          other_req;
  tag_t          tag_in;
  tag_t          tag_out;

  // Reader grants are gated by reset so every grant reads 0 while it is held.
  always_comb begin
    fft_pick  = 1'b0;
    host_pick = 1'b0;
    if (!reset && !adc_req) begin
      case (state)
        OWN_NONE: begin
          if (fft_req && (!host_req || !rr_host)) fft_pick = 1'b1;
          else if (host_req)                      host_pick = 1'b1;
        end
        OWN_FFT:  fft_pick  = fft_req;
        OWN_HOST: host_pick = host_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    owner_req = 1'b0;
    other_req = 1'b0;
    case (state)
      OWN_FFT: begin
        owner_req = fft_req;
        other_req = host_req;
      end
      OWN_HOST: begin
        owner_req = host_req;
        other_req = fft_req;
      end
      default: ;
    endcase
  end

  assign adc_gnt  = adc_req & ~reset;
  assign fft_gnt  = fft_pick;
  assign host_gnt = host_pick;
  assign beat     = fft_pick | host_pick;
  assign cnt_next = (beat && burst_cnt != BURST_LIMIT) ? burst_cnt + BW'(1) : burst_cnt;

  // A dropped owner request outranks burst expiry, so the waiting reader
  // comes in through OWN_NONE on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= OWN_NONE;
      rr_host   <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (fft_pick)       rr_host <= 1'b1;
      else if (host_pick) rr_host <= 1'b0;
      case (state)
        OWN_NONE: begin
          if (fft_pick) begin
            state     <= OWN_FFT;
            burst_cnt <= BW'(1);
          end else if (host_pick) begin
            state     <= OWN_HOST;
            burst_cnt <= BW'(1);
          end
        end
        default: begin
          if (!owner_req) begin
            state     <= OWN_NONE;
            burst_cnt <= '0;
          end else if (cnt_next == BURST_LIMIT && other_req) begin
            state     <= other_reader(state);
            burst_cnt <= '0;
          end else begin
            burst_cnt <= cnt_next;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= adc_gnt | beat;
      ram_we <= adc_gnt;
      if (adc_gnt) begin
        ram_addr  <= adc_addr;
        ram_wdata <= adc_wdata;
      end else if (fft_pick) begin
        ram_addr  <= fft_addr;
        ram_wdata <= '0;
      end else if (host_pick) begin
        ram_addr  <= host_addr;
        ram_wdata <= '0;
      end else begin
        ram_addr  <= '0;
        ram_wdata <= '0;
      end
    end
  end

  always_comb begin
    tag_in = TAG_NONE;
    if (fft_pick)       tag_in = TAG_FFT;
    else if (host_pick) tag_in = TAG_HOST;
  end

  rd_tag_pipe #(
    .DEPTH(RAM_LATENCY + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .busy    (busy)
  );

  assign fft_rvalid  = (tag_out == TAG_FFT);
  assign host_rvalid = (tag_out == TAG_HOST);
  assign fft_rdata   = fft_rvalid  ? ram_rdata : '0;
  assign host_rdata  = host_rvalid ? ram_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (((fft_req && !fft_pick) || (host_req && !host_pick)) && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_ram_arbiter.sv
// Randomised bench for sample_ram_arbiter: a RAM model plus a rule-level
// reference for grants, burst ownership, read returns and stall counting.
module tb_sample_ram_arbiter;

  localparam int AW   = 13;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int MAXB = 16;
  localparam int NW   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          adc_req, fft_req, host_req;
  logic [AW-1:0] adc_addr, fft_addr, host_addr;
  logic [DW-1:0] adc_wdata;
  logic          adc_gnt, fft_gnt, host_gnt;
  logic          fft_rvalid, host_rvalid;
  logic [DW-1:0] fft_rdata, host_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          busy;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  sample_ram_arbiter #(
    .AW(AW), .DW(DW), .RAM_LATENCY(LAT), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset),
    .adc_req(adc_req), .adc_addr(adc_addr), .adc_wdata(adc_wdata), .adc_gnt(adc_gnt),
    .fft_req(fft_req), .fft_addr(fft_addr), .fft_gnt(fft_gnt),
    .fft_rvalid(fft_rvalid), .fft_rdata(fft_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .stall_cnt(stall_cnt)
  );

  function automatic logic [DW-1:0] init_word(int a);
    return DW'(a * 40503 + 12345) ^ 16'hA5C3;
  endfunction

  // Behavioural RAM: address sampled while ram_en is high, data LAT cycles later.
  logic [DW-1:0] ram_mem [NW];
  logic [DW-1:0] ram_pipe [LAT];
  bit            ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < NW; i++) ram_mem[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (ram_en && ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    ram_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : DW'($urandom);
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  assign ram_rdata = ram_pipe[LAT-1];

  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } rd_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] ref_mem [NW];
  rd_t           pend [$];
  int            m_owner;
  int            m_beats;
  bit            m_favour_host;
  int            m_stall;
  bit            p_en, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  int            n_fft, n_host, n_adc, n_host_rv;
  int            first_gnt, first_rv;
  bit            last_fft_gnt, last_host_gnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic clearCounts();
    n_fft = 0; n_host = 0; n_adc = 0; n_host_rv = 0;
    first_gnt = -1; first_rv = -1;
  endtask

  task automatic modelReset();
    m_owner = 0; m_beats = 0; m_favour_host = 1'b0; m_stall = 0;
    p_en = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    pend.delete();
  endtask

  // Holds reset for n cycles with every request raised; all outputs must stay 0.
  task automatic applyReset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    adc_req = 1'b1; fft_req = 1'b1; host_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("rst_adc_gnt", 32'(adc_gnt), 32'd0);
      checkOutput("rst_fft_gnt", 32'(fft_gnt), 32'd0);
      checkOutput("rst_host_gnt", 32'(host_gnt), 32'd0);
      checkOutput("rst_ram", {14'd0, ram_en, ram_we, 16'(ram_addr)}, 32'd0);
      checkOutput("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      checkOutput("rst_rvalid", {30'd0, fft_rvalid, host_rvalid}, 32'd0);
      checkOutput("rst_rdata", {fft_rdata, host_rdata}, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      if (i < n - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    adc_req = 1'b0; fft_req = 1'b0; host_req = 1'b0;
    modelReset();
  endtask

  // One clock cycle: drive inputs, compare every output with the reference, advance the reference.
  task automatic applyStimulus(input logic a_req, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data,
                               input logic f_req, input logic [AW-1:0] f_addr,
                               input logic h_req, input logic [AW-1:0] h_addr);
    bit  e_fft, e_host, e_busy, own_req, oth_req;
    int  e_who;
    rd_t r;
    @(posedge clk); #1;
    adc_req = a_req; adc_addr = a_addr; adc_wdata = a_data;
    fft_req = f_req; fft_addr = f_addr;
    host_req = h_req; host_addr = h_addr;
    @(negedge clk);

    e_fft = 1'b0; e_host = 1'b0;
    if (!a_req) begin
      if (m_owner == 0) begin
        if (f_req && h_req) begin
          if (m_favour_host) e_host = 1'b1;
          else               e_fft  = 1'b1;
        end else begin
          e_fft  = f_req;
          e_host = h_req;
        end
      end else if (m_owner == 1) begin
        e_fft = f_req;
      end else begin
        e_host = h_req;
      end
    end

    checkOutput("adc_gnt", 32'(adc_gnt), 32'(a_req));
    checkOutput("fft_gnt", 32'(fft_gnt), 32'(e_fft));
    checkOutput("host_gnt", 32'(host_gnt), 32'(e_host));
    checkOutput("ram_en", 32'(ram_en), 32'(p_en));
    if (p_en) begin
      checkOutput("ram_we", 32'(ram_we), 32'(p_we));
      checkOutput("ram_addr", 32'(ram_addr), 32'(p_addr));
      if (p_we) checkOutput("ram_wdata", 32'(ram_wdata), 32'(p_wdata));
    end

    e_busy = (pend.size() > 0);
    e_who  = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      e_who = r.who;
      if (r.who == 1) checkOutput("fft_rdata", 32'(fft_rdata), 32'(r.data));
      else            checkOutput("host_rdata", 32'(host_rdata), 32'(r.data));
    end
    checkOutput("fft_rvalid", 32'(fft_rvalid), 32'(e_who == 1));
    checkOutput("host_rvalid", 32'(host_rvalid), 32'(e_who == 2));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));

    last_fft_gnt = fft_gnt; last_host_gnt = host_gnt;
    if (fft_gnt) n_fft++;
    if (host_gnt) n_host++;
    if (adc_gnt) n_adc++;
    if (host_rvalid) n_host_rv++;
    if (fft_gnt && first_gnt < 0) first_gnt = cyc;
    if (fft_rvalid && first_rv < 0) first_rv = cyc;

    if ((f_req && !e_fft) || (h_req && !e_host)) m_stall = (m_stall < 16'hFFFF) ? m_stall + 1 : m_stall;
    p_en = a_req | e_fft | e_host;
    p_we = a_req;
    p_addr = a_req ? a_addr : (e_fft ? f_addr : h_addr);
    p_wdata = a_data;
    if (a_req) ref_mem[a_addr] = a_data;
    if (e_fft || e_host) begin
      r.due = cyc + 1 + LAT;
      r.who = e_fft ? 1 : 2;
      r.data = ref_mem[e_fft ? f_addr : h_addr];
      pend.push_back(r);
    end

    if (m_owner == 0) begin
      if (e_fft)       begin m_owner = 1; m_beats = 1; end
      else if (e_host) begin m_owner = 2; m_beats = 1; end
    end else begin
      own_req = (m_owner == 1) ? f_req : h_req;
      oth_req = (m_owner == 1) ? h_req : f_req;
      if (!own_req) begin
        m_owner = 0; m_beats = 0;
      end else begin
        if ((e_fft || e_host) && m_beats < MAXB) m_beats++;
        if (m_beats == MAXB && oth_req) begin
          m_owner = 3 - m_owner; m_beats = 0;
        end
      end
    end
    if (e_fft)  m_favour_host = 1'b1;
    if (e_host) m_favour_host = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    bit f_on, h_on;
    reset = 1'b1;
    adc_req = 1'b0; fft_req = 1'b0; host_req = 1'b0;
    adc_addr = '0; fft_addr = '0; host_addr = '0; adc_wdata = '0;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    modelReset();
    clearCounts();
    applyReset(3);

    $display("[TB] fft streaming addresses 0..31 alone");
    clearCounts();
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, '0);
    idle(4);
    checkOutput("stream_fft_grants", 32'(n_fft), 32'd32);
    checkOutput("first_rvalid_latency", 32'(first_rv - first_gnt), 32'd3);

    $display("[TB] fft and host contending");
    applyReset(1);
    clearCounts();
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(100 + i), 1'b1, AW'(900 + i));
    checkOutput("contend_fft_grants", 32'(n_fft), 32'd32);
    checkOutput("contend_host_grants", 32'(n_host), 32'd32);
    idle(1);
    checkOutput("contend_stall_cnt", 32'(stall_cnt), 32'd64);
    idle(4);

    $display("[TB] adc pulses during an fft burst");
    clearCounts();
    for (int i = 0; i < 40; i++)
      applyStimulus(i % 4 == 3, AW'(i), DW'($urandom), 1'b1, AW'(i), 1'b0, '0);
    checkOutput("adc_pulse_grants", 32'(n_adc), 32'd10);
    checkOutput("adc_fft_grants", 32'(n_fft), 32'd30);
    idle(4);

    $display("[TB] fft drops mid-burst while host waits");
    applyReset(1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), i >= 5, AW'(50));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(51));
    checkOutput("drop_gap_host_gnt", 32'(last_host_gnt), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(52));
    checkOutput("drop_next_host_gnt", 32'(last_host_gnt), 32'd1);
    idle(4);

    $display("[TB] owner drop coinciding with saturated burst");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(60));
    checkOutput("sat_drop_host_gnt", 32'(last_host_gnt), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(61));
    checkOutput("sat_next_host_gnt", 32'(last_host_gnt), 32'd1);
    idle(4);

    $display("[TB] reset right after a host read");
    clearCounts();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(77));
    applyReset(2);
    clearCounts();
    idle(6);
    checkOutput("reset_host_rvalids", 32'(n_host_rv), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);

    $display("[TB] host alone for 300 cycles");
    clearCounts();
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'($urandom));
    checkOutput("host_alone_grants", 32'(n_host), 32'd300);
    checkOutput("host_alone_stall", 32'(stall_cnt), 32'd0);
    idle(4);

    $display("[TB] randomised traffic");
    f_on = 1'b0; h_on = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) f_on = !f_on;
      if ($urandom_range(0, 7) == 0) h_on = !h_on;
      applyStimulus($urandom_range(0, 4) == 0, AW'($urandom_range(0, 63)), DW'($urandom),
                    f_on, AW'($urandom_range(0, 63)), h_on, AW'($urandom_range(0, 63)));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
